// File: rtl/apb_uart_multi.sv
// apb_uart_multi: NrChannels 8N1 UARTs behind one APB slave.
// Ports: clk_i/rst_i, APB (psel/penable/pwrite/paddr/pwdata ->
// prdata/pready/pslverr), rx_i/tx_o serial lines, irq_o per channel.

module apb_uart_ch #(
  parameter int          FifoDepth  = 4,
  parameter logic [15:0] DefaultDiv = 16'd433
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        acc_i,
  input  logic        we_i,
  input  logic [1:0]  reg_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        err_o,
  input  logic        rx_i,
  output logic        tx_o,
  output logic        irq_o
);

  localparam int AW = $clog2(FifoDepth);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] Full = CW'(FifoDepth);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} st_e;

  logic [7:0]    tmem_q [FifoDepth];
  logic [7:0]    rmem_q [FifoDepth];
  logic [AW-1:0] twp_q, twp_d, trp_q, trp_d;
  logic [AW-1:0] rwp_q, rwp_d, rrp_q, rrp_d;
  logic [CW-1:0] tcnt_q, tcnt_d, rcnt_q, rcnt_d;
  logic [15:0]   div_q, div_d;
  logic [3:0]    ctrl_q, ctrl_d;
  logic          ovr_q, ovr_d, ferr_q, ferr_d;
  logic          irq_q, irq_d;
  st_e           txs_q, txs_d, rxs_q, rxs_d;
  logic [15:0]   tctr_q, tctr_d, tdiv_q, tdiv_d;
  logic [2:0]    tbit_q, tbit_d;
  logic [7:0]    tsh_q, tsh_d;
  logic          tx_q, tx_d;
  logic [2:0]    sync_q;
  logic [15:0]   rctr_q, rctr_d, rdiv_q, rdiv_d;
  logic [2:0]    rbit_q, rbit_d;
  logic [7:0]    rsh_q, rsh_d;

  logic wr, rd, tfull, tempty, rfull, rempty;
  logic tpush, tpop, rpop, rpush, rdone, rbad;
  logic tgo, tend, rend, tlaunch;
  logic [16:0] half;
  logic [15:0] wdiv;
  logic unused_ok;

  assign wr     = acc_i & we_i;
  assign rd     = acc_i & ~we_i;
  assign tfull  = tcnt_q == Full;
  assign tempty = tcnt_q == '0;
  assign rfull  = rcnt_q == Full;
  assign rempty = rcnt_q == '0;
  assign tpush  = wr & (reg_i == 2'd0) & ~tfull;
  assign rpop   = rd & (reg_i == 2'd0) & ~rempty;
  // a full RX FIFO still accepts when popped in the same cycle
  assign rpush  = rdone & (~rfull | rpop);
  assign tpop   = tlaunch;
  assign tgo    = ctrl_q[0] & ~tempty;
  assign tend   = tctr_q == tdiv_q;
  assign rend   = rctr_q == rdiv_q;
  // last count of the floor((DIV+1)/2) start-bit wait
  assign half   = (({1'b0, rdiv_q} + 17'd1) >> 1) - 17'd1;
  assign wdiv   = (wdata_i[15:0] < 16'd3) ? 16'd3 : wdata_i[15:0];
  assign unused_ok = ^wdata_i[31:16];
  assign tx_o   = tx_q;
  assign irq_o  = irq_q;

  assign err_o = we_i & ((reg_i == 2'd1) |
                         ((reg_i == 2'd0) & tfull));

  always_comb begin
    rdata_o = '0;
    unique case (reg_i)
      2'd0: rdata_o = {23'd0, rempty,
                       rempty ? 8'd0 : rmem_q[rrp_q]};
      2'd1: rdata_o = {25'd0, txs_q != IDLE, ferr_q, ovr_q,
                       rempty, rfull, tempty, tfull};
      2'd2: rdata_o = {16'd0, div_q};
      2'd3: rdata_o = {28'd0, ctrl_q};
    endcase
  end

  always_comb begin
    div_d  = div_q;
    ctrl_d = ctrl_q;
    ovr_d  = ovr_q;
    ferr_d = ferr_q;
    if (wr && reg_i == 2'd2) div_d = wdiv;
    if (wr && reg_i == 2'd3) begin
      ctrl_d = wdata_i[3:0];
      if (wdata_i[4]) ovr_d = 1'b0;
      if (wdata_i[5]) ferr_d = 1'b0;
    end
    if (rdone && rfull && !rpop) ovr_d = 1'b1;
    if (rbad) ferr_d = 1'b1;
    twp_d  = twp_q + AW'(tpush);
    trp_d  = trp_q + AW'(tpop);
    tcnt_d = tcnt_q + CW'(tpush) - CW'(tpop);
    rwp_d  = rwp_q + AW'(rpush);
    rrp_d  = rrp_q + AW'(rpop);
    rcnt_d = rcnt_q + CW'(rpush) - CW'(rpop);
    irq_d  = (ctrl_q[2] & ~rempty) |
             (ctrl_q[3] & tempty & (txs_q == IDLE)) |
             ovr_q | ferr_q;
  end

  always_comb begin
    txs_d   = txs_q;
    tctr_d  = tctr_q + 16'd1;
    tbit_d  = tbit_q;
    tsh_d   = tsh_q;
    tdiv_d  = tdiv_q;
    tx_d    = tx_q;
    tlaunch = 1'b0;
    unique case (txs_q)
      IDLE: begin
        tctr_d  = '0;
        tx_d    = 1'b1;
        tlaunch = tgo;
      end
      START: if (tend) begin
        tctr_d = '0;
        tbit_d = '0;
        tx_d   = tsh_q[0];
        txs_d  = DATA;
      end
      DATA: if (tend) begin
        tctr_d = '0;
        tbit_d = tbit_q + 3'd1;
        tsh_d  = tsh_q >> 1;
        tx_d   = tsh_q[1];
        if (tbit_q == 3'd7) begin
          tx_d  = 1'b1;
          txs_d = STOP;
        end
      end
      STOP: if (tend) begin
        txs_d   = IDLE;
        tlaunch = tgo;
      end
    endcase
    // STOP chains straight into the next START
    if (tlaunch) begin
      txs_d  = START;
      tctr_d = '0;
      tsh_d  = tmem_q[trp_q];
      tdiv_d = div_q;
      tx_d   = 1'b0;
    end
  end

  always_comb begin
    rxs_d  = rxs_q;
    rctr_d = rctr_q + 16'd1;
    rbit_d = rbit_q;
    rsh_d  = rsh_q;
    rdiv_d = rdiv_q;
    rdone  = 1'b0;
    rbad   = 1'b0;
    unique case (rxs_q)
      IDLE: begin
        rctr_d = '0;
        if (ctrl_q[1] && sync_q[2] && !sync_q[1]) begin
          rxs_d  = START;
          rdiv_d = div_q;
        end
      end
      START: if ({1'b0, rctr_q} == half) begin
        rctr_d = '0;
        rbit_d = '0;
        rxs_d  = sync_q[1] ? IDLE : DATA;
      end
      DATA: if (rend) begin
        rctr_d = '0;
        rsh_d  = {sync_q[1], rsh_q[7:1]};
        rbit_d = rbit_q + 3'd1;
        if (rbit_q == 3'd7) rxs_d = STOP;
      end
      STOP: if (rend) begin
        rxs_d = IDLE;
        rdone = sync_q[1];
        rbad  = ~sync_q[1];
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      twp_q  <= '0; trp_q <= '0; tcnt_q <= '0;
      rwp_q  <= '0; rrp_q <= '0; rcnt_q <= '0;
      div_q  <= DefaultDiv;
      ctrl_q <= '0;
      ovr_q  <= 1'b0;
      ferr_q <= 1'b0;
      irq_q  <= 1'b0;
      txs_q  <= IDLE; tctr_q <= '0; tdiv_q <= '0;
      tbit_q <= '0;   tsh_q  <= '0; tx_q   <= 1'b1;
      sync_q <= 3'b111;
      rxs_q  <= IDLE; rctr_q <= '0; rdiv_q <= '0;
      rbit_q <= '0;   rsh_q  <= '0;
    end else begin
      twp_q  <= twp_d; trp_q <= trp_d; tcnt_q <= tcnt_d;
      rwp_q  <= rwp_d; rrp_q <= rrp_d; rcnt_q <= rcnt_d;
      div_q  <= div_d;
      ctrl_q <= ctrl_d;
      ovr_q  <= ovr_d;
      ferr_q <= ferr_d;
      irq_q  <= irq_d;
      txs_q  <= txs_d; tctr_q <= tctr_d; tdiv_q <= tdiv_d;
      tbit_q <= tbit_d; tsh_q <= tsh_d; tx_q   <= tx_d;
      sync_q <= {sync_q[1:0], rx_i};
      rxs_q  <= rxs_d; rctr_q <= rctr_d; rdiv_q <= rdiv_d;
      rbit_q <= rbit_d; rsh_q <= rsh_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (tpush) tmem_q[twp_q] <= wdata_i[7:0];
    if (rpush) rmem_q[rwp_q] <= rsh_q;
  end

endmodule

module apb_uart_multi #(
  parameter int          NrChannels = 2,
  parameter int          FifoDepth  = 4,
  parameter int          AddrWidth  = 32,
  parameter logic [15:0] DefaultDiv = 16'd433
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic                  pwrite_i,
  input  logic [AddrWidth-1:0]  paddr_i,
  input  logic [31:0]           pwdata_i,
  output logic [31:0]           prdata_o,
  output logic                  pready_o,
  output logic                  pslverr_o,
  input  logic [NrChannels-1:0] rx_i,
  output logic [NrChannels-1:0] tx_o,
  output logic [NrChannels-1:0] irq_o
);

  logic        pready_q, pready_d;
  logic        pslverr_q, pslverr_d;
  logic [31:0] prdata_q, prdata_d;
  logic        acc;
  logic [2:0]  ch;
  logic [31:0] rd [NrChannels];
  logic [NrChannels-1:0] err;
  logic [31:0] rsel;
  logic        esel;
  logic        unused_ok;

  // ~pready_q keeps a held access from firing twice
  assign acc = psel_i & penable_i & ~pready_q;
  assign ch  = paddr_i[6:4];
  assign unused_ok = ^{paddr_i[AddrWidth-1:7], paddr_i[1:0]};

  for (genvar g = 0; g < NrChannels; g++) begin : g_ch
    apb_uart_ch #(
      .FifoDepth (FifoDepth),
      .DefaultDiv(DefaultDiv)
    ) u_ch (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .acc_i  (acc && ch == 3'(g)),
      .we_i   (pwrite_i),
      .reg_i  (paddr_i[3:2]),
      .wdata_i(pwdata_i),
      .rdata_o(rd[g]),
      .err_o  (err[g]),
      .rx_i   (rx_i[g]),
      .tx_o   (tx_o[g]),
      .irq_o  (irq_o[g])
    );
  end

  // unmapped channel: error with zero data
  always_comb begin
    rsel = '0;
    esel = 1'b1;
    for (int c = 0; c < NrChannels; c++) begin
      if (ch == 3'(c)) begin
        rsel = rd[c];
        esel = err[c];
      end
    end
    pready_d  = acc;
    prdata_d  = acc ? rsel : '0;
    pslverr_d = acc & esel;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  assign pready_o  = pready_q;
  assign pslverr_o = pslverr_q;
  assign prdata_o  = prdata_q;

endmodule

// File: tb/tb_apb_uart_multi.sv
// tb_apb_uart_multi: directed bench for apb_uart_multi.
// ch0 tx loops back to ch1 rx; ch0 rx driven by the bench.

module tb_apb_uart_multi;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic [1:0]  rx, tx, irq;
  logic        rx0 = 1'b1;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int edges[$];
  logic mon = 1'b0;
  logic tprev = 1'b1;

  logic [31:0] r;
  logic        e;
  logic [39:0] cap, expv;
  logic [9:0]  fb;
  int          k;

  assign rx = {tx[0], rx0};

  apb_uart_multi dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .psel_i   (psel),
    .penable_i(penable),
    .pwrite_i (pwrite),
    .paddr_i  (paddr),
    .pwdata_i (pwdata),
    .prdata_o (prdata),
    .pready_o (pready),
    .pslverr_o(pslverr),
    .rx_i     (rx),
    .tx_o     (tx),
    .irq_o    (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (mon && tx[0] !== tprev) edges.push_back(cyc);
    tprev <= tx[0];
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic apb(input logic w, input logic [31:0] a,
                     input logic [31:0] d,
                     output logic [31:0] rdat, output logic err);
    int n;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0;
    pwrite = w; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (!pready && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    chk("apb_ready", 32'(pready), 32'd1);
    rdat = prdata;
    err  = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] x;
    logic        y;
    apb(1'b1, a, d, x, y);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    logic y;
    apb(1'b0, a, 32'd0, d, y);
  endtask

  task automatic send(input logic [7:0] b, input logic stp);
    logic [9:0] f;
    f = {stp, b, 1'b0};
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      rx0 = f[i];
      repeat (4) @(posedge clk);
      #1;
    end
    rx0 = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic wait_fall(input string tag);
    int n;
    n = 0;
    while (tx[0] !== 1'b0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, 32'(tx[0]), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_tx", 32'(tx), 32'h3);
    chk("rst_pready", 32'(pready), 32'h0);
    chk("rst_prdata", prdata, 32'h0);
    chk("rst_pslverr", 32'(pslverr), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    rd(32'h04, r); chk("rst_status", r, 32'h0A);
    rd(32'h08, r); chk("rst_div", r, 32'h1B1);
    rd(32'h0C, r); chk("rst_ctrl", r, 32'h0);
    chk("pready_pulse", 32'(pready), 32'h0);

    wr(32'h08, 32'h1);
    rd(32'h08, r); chk("div_clamp", r, 32'h3);

    // TX frame timing, 0x55 at DIV=3
    wr(32'h0C, 32'h1);
    wr(32'h00, 32'h55);
    wait_fall("tx_start");
    for (int i = 0; i < 40; i++) begin
      cap[i] = tx[0];
      @(posedge clk); #1;
    end
    fb = {1'b1, 8'h55, 1'b0};
    for (int i = 0; i < 40; i++) expv[i] = fb[i / 4];
    chk("tx_wave_lo", cap[31:0], expv[31:0]);
    chk("tx_wave_hi", 32'(cap[39:32]), 32'(expv[39:32]));
    chk("tx_idle", 32'(tx[0]), 32'h1);
    rd(32'h04, r); chk("tx_done_status", r, 32'h0A);
    wr(32'h00, 32'h55);
    rd(32'h04, r); chk("tx_busy_status", r, 32'h4A);
    repeat (50) @(posedge clk);
    #1;

    // loopback ch0 -> ch1
    wr(32'h18, 32'h3);
    wr(32'h1C, 32'h6);
    wr(32'h00, 32'hA5);
    wr(32'h00, 32'h3C);
    repeat (100) @(posedge clk);
    #1;
    chk("lb_irq_hi", 32'(irq), 32'h2);
    rd(32'h10, r); chk("lb_rx0", r, 32'h0A5);
    rd(32'h10, r); chk("lb_rx1", r, 32'h03C);
    rd(32'h10, r); chk("lb_rx_empty", r, 32'h100);
    chk("lb_irq_lo", 32'(irq[1]), 32'h0);

    // overrun on ch0
    wr(32'h0C, 32'h2);
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b1);
    rd(32'h04, r); chk("ovr_status", r, 32'h16);
    chk("ovr_irq", 32'(irq[0]), 32'h1);
    for (int i = 1; i <= 4; i++) begin
      rd(32'h00, r); chk("ovr_data", r, 32'(i));
    end
    rd(32'h00, r); chk("ovr_empty", r, 32'h100);
    wr(32'h0C, 32'h12);
    chk("ovr_irq_clr", 32'(irq[0]), 32'h0);
    rd(32'h04, r); chk("ovr_clr_status", r, 32'h0A);

    // framing error
    send(8'h77, 1'b0);
    rd(32'h04, r); chk("ferr_status", r, 32'h2A);
    chk("ferr_irq", 32'(irq[0]), 32'h1);
    wr(32'h0C, 32'h22);
    rd(32'h04, r); chk("ferr_clr_status", r, 32'h0A);

    // access errors
    apb(1'b1, 32'h04, 32'h0, r, e);
    chk("status_wr_err", 32'(e), 32'h1);
    apb(1'b0, 32'h20, 32'h0, r, e);
    chk("bad_ch_err", 32'(e), 32'h1);
    chk("bad_ch_data", r, 32'h0);
    apb(1'b1, 32'h24, 32'h0, r, e);
    chk("bad_ch_wr_err", 32'(e), 32'h1);
    apb(1'b0, 32'h08, 32'h0, r, e);
    chk("good_rd_err", 32'(e), 32'h0);

    // TX FIFO full with tx disabled
    wr(32'h0C, 32'h0);
    for (int i = 1; i <= 5; i++) begin
      apb(1'b1, 32'h00, 32'(8'h11 * i), r, e);
      chk("tx_fill_err", 32'(e), (i == 5) ? 32'h1 : 32'h0);
    end
    rd(32'h04, r); chk("tx_full_status", r, 32'h09);

    // reset during data bit 3 of 0x11
    wr(32'h0C, 32'h1);
    wait_fall("rst_frame_start");
    repeat (17) begin
      @(posedge clk); #1;
    end
    chk("rst_bit3", 32'(tx[0]), 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_tx", 32'(tx), 32'h3);
    rst = 1'b0;
    chk("rst_mid_irq", 32'(irq), 32'h0);
    rd(32'h04, r); chk("rst_mid_status", r, 32'h0A);
    rd(32'h08, r); chk("rst_mid_div", r, 32'h1B1);
    rd(32'h0C, r); chk("rst_mid_ctrl", r, 32'h0);

    // DIV change mid-frame
    wr(32'h08, 32'h3);
    wr(32'h0C, 32'h1);
    edges.delete();
    mon = 1'b1;
    wr(32'h00, 32'h00);
    wr(32'h00, 32'hFF);
    wr(32'h08, 32'h7);
    repeat (130) @(posedge clk);
    #1;
    mon = 1'b0;
    chk("div_edges", 32'(edges.size() >= 4), 32'h1);
    if (edges.size() >= 4) begin
      k = edges[1] - edges[0];
      chk("div_old_low", 32'(k), 32'd36);
      k = edges[2] - edges[1];
      chk("div_old_stop", 32'(k), 32'd4);
      k = edges[3] - edges[2];
      chk("div_new_start", 32'(k), 32'd8);
    end
    chk("div_idle", 32'(tx[0]), 32'h1);
    rd(32'h08, r); chk("div_new_val", r, 32'h7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
